// File: rtl/status_array_ctrl.sv
// status_array_ctrl: sequencer/arbiter in front of the 1R1W status SRAM.
// Zero-sweeps every row after reset and on flush, then round-robins the
// array between the lookup (read) and fill (write) requesters, never issuing
// a read and a write in the same cycle.
// Optional build macro: STATUS_CTRL_PERF_EN enables the conflict counter.
module status_array_ctrl #(
   parameter int unsigned TAG_WIDTH  = 1,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned NUM_ROWS   = 16,
   parameter int unsigned ROW_WIDTH  = 8,
   parameter int unsigned NUM_BLOCKS = 8
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  i_lk_valid,
   input  logic [ADDR_WIDTH-1:0] i_lk_addr,
   input  logic [TAG_WIDTH-1:0]  i_lk_tag,
   output logic                  o_lk_ready,
   input  logic                  i_fill_valid,
   input  logic [ADDR_WIDTH-1:0] i_fill_addr,
   input  logic [ROW_WIDTH-1:0]  i_fill_data,
   input  logic [NUM_BLOCKS-1:0] i_fill_wmask,
   output logic                  o_fill_ready,
   input  logic                  i_flush,
   output logic                  o_init_done,
   input  logic                  i_sa_ready,
   output logic                  o_sa_r_valid,
   output logic [ADDR_WIDTH-1:0] o_sa_r_addr,
   output logic [TAG_WIDTH-1:0]  o_sa_tag,
   output logic                  o_sa_w_valid,
   output logic [ADDR_WIDTH-1:0] o_sa_w_addr,
   output logic [ROW_WIDTH-1:0]  o_sa_w_data,
   output logic [NUM_BLOCKS-1:0] o_sa_w_wmask,
   output logic [15:0]           o_conflict_cnt
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   typedef enum logic {
      GNT_LK   = 1'b0,
      GNT_FILL = 1'b1
   } grant_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(NUM_ROWS - 1);

   state_t                  state, state_nxt;
   grant_t                  last_grant, last_grant_nxt;
   logic [ADDR_WIDTH-1:0]   row_cnt;
   logic                    last_row;
   logic                    sweep;
   logic                    grant_lk;
   logic                    grant_fill;

   assign last_row     = (row_cnt == LAST_ROW);
   assign o_lk_ready   = grant_lk;
   assign o_fill_ready = grant_fill;
   assign o_init_done  = (state == ST_RUN);

   // Next-state, sweep enable and round-robin grant; everything idles while the array is halted.
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      sweep          = 1'b0;
      grant_lk       = 1'b0;
      grant_fill     = 1'b0;
      if (i_sa_ready) begin
         case (state)
            ST_INIT, ST_FLUSH: begin
               sweep = 1'b1;
               if (last_row) state_nxt = ST_RUN;
            end
            ST_RUN: begin
               if (i_flush) begin
                  state_nxt = ST_FLUSH;
               end else if (i_lk_valid && i_fill_valid) begin
                  if (last_grant == GNT_FILL) grant_lk   = 1'b1;
                  else                        grant_fill = 1'b1;
               end else if (i_lk_valid) begin
                  grant_lk = 1'b1;
               end else if (i_fill_valid) begin
                  grant_fill = 1'b1;
               end
               if (grant_lk)        last_grant_nxt = GNT_LK;
               else if (grant_fill) last_grant_nxt = GNT_FILL;
            end
            default: state_nxt = ST_INIT;
         endcase
      end
   end

   // State, round-robin pointer and sweep row counter.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state      <= ST_INIT;
         last_grant <= GNT_FILL;
         row_cnt    <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         if (sweep) row_cnt <= last_row ? '0 : row_cnt + 1'b1;
      end
   end

   // Registered array command port; address/data/tag registers only load on their own grant.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         o_sa_r_valid <= 1'b0;
         o_sa_r_addr  <= '0;
         o_sa_tag     <= '0;
         o_sa_w_valid <= 1'b0;
         o_sa_w_addr  <= '0;
         o_sa_w_data  <= '0;
         o_sa_w_wmask <= '0;
      end else if (i_sa_ready) begin
         if (sweep) begin
            o_sa_r_valid <= 1'b0;
            o_sa_w_valid <= 1'b1;
            o_sa_w_addr  <= row_cnt;
            o_sa_w_data  <= '0;
            o_sa_w_wmask <= '1;
         end else begin
            o_sa_r_valid <= grant_lk;
            o_sa_w_valid <= grant_fill;
            if (grant_lk) begin
               o_sa_r_addr <= i_lk_addr;
               o_sa_tag    <= i_lk_tag;
            end
            if (grant_fill) begin
               o_sa_w_addr  <= i_fill_addr;
               o_sa_w_data  <= i_fill_data;
               o_sa_w_wmask <= i_fill_wmask;
            end
         end
      end
   end

`ifdef STATUS_CTRL_PERF_EN
   logic [15:0] conflict_cnt;

   // Counts RUN cycles where both requesters compete and one of them stalls; saturating.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         conflict_cnt <= '0;
      end else if ((state == ST_RUN) && i_sa_ready && i_lk_valid && i_fill_valid &&
                   !i_flush && (conflict_cnt != 16'hFFFF)) begin
         conflict_cnt <= conflict_cnt + 16'd1;
      end
   end

   assign o_conflict_cnt = conflict_cnt;
`else
   assign o_conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_status_array_ctrl.sv
// Directed self-checking bench for status_array_ctrl with a one-deep
// expected-command scoreboard (pushed when a cycle is driven, popped after the edge).
module tb_status_array_ctrl;

   logic        clk;
   logic        arst_n;
   logic        i_lk_valid;
   logic [3:0]  i_lk_addr;
   logic [0:0]  i_lk_tag;
   logic        o_lk_ready;
   logic        i_fill_valid;
   logic [3:0]  i_fill_addr;
   logic [7:0]  i_fill_data;
   logic [7:0]  i_fill_wmask;
   logic        o_fill_ready;
   logic        i_flush;
   logic        o_init_done;
   logic        i_sa_ready;
   logic        o_sa_r_valid;
   logic [3:0]  o_sa_r_addr;
   logic [0:0]  o_sa_tag;
   logic        o_sa_w_valid;
   logic [3:0]  o_sa_w_addr;
   logic [7:0]  o_sa_w_data;
   logic [7:0]  o_sa_w_wmask;
   logic [15:0] o_conflict_cnt;

`ifdef STATUS_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic       rv;
      logic       wv;
      logic [3:0] ra;
      logic       tag;
      logic [3:0] wa;
      logic [7:0] wd;
      logic [7:0] wm;
   } exp_t;

   exp_t sb[$];
   exp_t last_e;
   int   n_assert;
   int   n_fail;

   status_array_ctrl #(
      .TAG_WIDTH (1),
      .ADDR_WIDTH(4),
      .NUM_ROWS  (16),
      .ROW_WIDTH (8),
      .NUM_BLOCKS(8)
   ) dut (
      .clk           (clk),
      .arst_n        (arst_n),
      .i_lk_valid    (i_lk_valid),
      .i_lk_addr     (i_lk_addr),
      .i_lk_tag      (i_lk_tag),
      .o_lk_ready    (o_lk_ready),
      .i_fill_valid  (i_fill_valid),
      .i_fill_addr   (i_fill_addr),
      .i_fill_data   (i_fill_data),
      .i_fill_wmask  (i_fill_wmask),
      .o_fill_ready  (o_fill_ready),
      .i_flush       (i_flush),
      .o_init_done   (o_init_done),
      .i_sa_ready    (i_sa_ready),
      .o_sa_r_valid  (o_sa_r_valid),
      .o_sa_r_addr   (o_sa_r_addr),
      .o_sa_tag      (o_sa_tag),
      .o_sa_w_valid  (o_sa_w_valid),
      .o_sa_w_addr   (o_sa_w_addr),
      .o_sa_w_data   (o_sa_w_data),
      .o_sa_w_wmask  (o_sa_w_wmask),
      .o_conflict_cnt(o_conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected end of test");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_r_valid"},  32'(o_sa_r_valid),   32'h0);
      chk({tag, "_w_valid"},  32'(o_sa_w_valid),   32'h0);
      chk({tag, "_r_addr"},   32'(o_sa_r_addr),    32'h0);
      chk({tag, "_tag"},      32'(o_sa_tag),       32'h0);
      chk({tag, "_w_addr"},   32'(o_sa_w_addr),    32'h0);
      chk({tag, "_w_data"},   32'(o_sa_w_data),    32'h0);
      chk({tag, "_w_wmask"},  32'(o_sa_w_wmask),   32'h0);
      chk({tag, "_lk_rdy"},   32'(o_lk_ready),     32'h0);
      chk({tag, "_fill_rdy"}, 32'(o_fill_ready),   32'h0);
      chk({tag, "_done"},     32'(o_init_done),    32'h0);
      chk({tag, "_cnt"},      32'(o_conflict_cnt), 32'h0);
   endtask

   // One clock: drive, check readies at negedge, push expectation, check command after edge.
   task automatic drive_cycle(
      input logic       lk_v, input logic [3:0] lk_a, input logic lk_t,
      input logic       f_v,  input logic [3:0] f_a,  input logic [7:0] f_d, input logic [7:0] f_m,
      input logic       flush, input logic sa_rdy,
      input logic       exp_lk, input logic exp_fill, input logic exp_done,
      input logic       is_sweep, input logic [3:0] row);
      exp_t e;
      exp_t got;
      i_lk_valid   = lk_v;
      i_lk_addr    = lk_a;
      i_lk_tag     = lk_t;
      i_fill_valid = f_v;
      i_fill_addr  = f_a;
      i_fill_data  = f_d;
      i_fill_wmask = f_m;
      i_flush      = flush;
      i_sa_ready   = sa_rdy;
      @(negedge clk);
      chk("lk_ready",   32'(o_lk_ready),   32'(exp_lk));
      chk("fill_ready", 32'(o_fill_ready), 32'(exp_fill));
      chk("init_done",  32'(o_init_done),  32'(exp_done));
      e = '0;
      if (!sa_rdy) e = last_e;
      else if (is_sweep) begin
         e.wv = 1'b1; e.wa = row; e.wd = 8'h00; e.wm = 8'hFF;
      end else if (exp_lk) begin
         e.rv = 1'b1; e.ra = lk_a; e.tag = lk_t;
      end else if (exp_fill) begin
         e.wv = 1'b1; e.wa = f_a; e.wd = f_d; e.wm = f_m;
      end
      last_e = e;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      chk("rw_exclusive", 32'(o_sa_r_valid & o_sa_w_valid), 32'h0);
      chk("r_valid", 32'(o_sa_r_valid), 32'(got.rv));
      chk("w_valid", 32'(o_sa_w_valid), 32'(got.wv));
      if (got.rv) begin
         chk("r_addr", 32'(o_sa_r_addr), 32'(got.ra));
         chk("r_tag",  32'(o_sa_tag),    32'(got.tag));
      end
      if (got.wv) begin
         chk("w_addr",  32'(o_sa_w_addr),  32'(got.wa));
         chk("w_data",  32'(o_sa_w_data),  32'(got.wd));
         chk("w_wmask", 32'(o_sa_w_wmask), 32'(got.wm));
      end
   endtask

   // Sweep rows 0..nrows-1 while holding the given requests; flush stays high for the first flush_rows.
   task automatic sweep_rows(input int nrows, input logic lk_v, input logic f_v,
                             input logic [3:0] f_a, input logic [7:0] f_d, input logic [7:0] f_m,
                             input int flush_rows);
      for (int r = 0; r < nrows; r++) begin
         drive_cycle(lk_v, 4'h3, 1'b1, f_v, f_a, f_d, f_m, (r < flush_rows), 1'b1,
                     1'b0, 1'b0, 1'b0, 1'b1, 4'(r));
      end
   endtask

   task automatic idle_inputs();
      i_lk_valid = 1'b0; i_lk_addr = '0; i_lk_tag = '0;
      i_fill_valid = 1'b0; i_fill_addr = '0; i_fill_data = '0; i_fill_wmask = '0;
      i_flush = 1'b0; i_sa_ready = 1'b1;
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      last_e   = '0;
      idle_inputs();
      arst_n = 1'b0;
      i_lk_valid = 1'b1;
      i_fill_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      arst_n = 1'b1;

      // Reset sweep with a lookup pending: no ready until RUN.
      sweep_rows(16, 1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 0);

      // Lookup alone in the first RUN cycle.
      drive_cycle(1'b1, 4'h3, 1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
      // Fill alone: pointer now at FILL.
      drive_cycle(1'b0, 4'h0, 1'b0, 1'b1, 4'h5, 8'hA5, 8'h0F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);

      // Both valid for four cycles: LK, FILL, LK, FILL.
      drive_cycle(1'b1, 4'h1, 1'b0, 1'b1, 4'h2, 8'h11, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
      drive_cycle(1'b1, 4'h4, 1'b1, 1'b1, 4'h6, 8'h22, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      drive_cycle(1'b1, 4'h7, 1'b1, 1'b1, 4'h8, 8'h33, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
      drive_cycle(1'b1, 4'h9, 1'b0, 1'b1, 4'hA, 8'h44, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      chk("conflict_cnt_4", 32'(o_conflict_cnt), PERF ? 32'd4 : 32'd0);

      // Array halted for three cycles with both valid: outputs frozen.
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b1, 4'hB, 1'b1, 1'b1, 4'hC, 8'h55, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
      end
      chk("conflict_cnt_halt", 32'(o_conflict_cnt), PERF ? 32'd4 : 32'd0);
      // Resume: order continues with LK then FILL.
      drive_cycle(1'b1, 4'hB, 1'b1, 1'b1, 4'hC, 8'h55, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);
      drive_cycle(1'b1, 4'hB, 1'b1, 1'b1, 4'hC, 8'h55, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      chk("conflict_cnt_6", 32'(o_conflict_cnt), PERF ? 32'd6 : 32'd0);

      // Fill then lookup of the same row issue in order.
      drive_cycle(1'b0, 4'h0, 1'b0, 1'b1, 4'h9, 8'h66, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      drive_cycle(1'b1, 4'h9, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0);

      // Flush with a fill pending: fill stalls, sweep runs, fill accepted in first RUN cycle.
      drive_cycle(1'b0, 4'h0, 1'b0, 1'b1, 4'hD, 8'h77, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
      sweep_rows(16, 1'b0, 1'b1, 4'hD, 8'h77, 8'hF0, 5);
      drive_cycle(1'b0, 4'h0, 1'b0, 1'b1, 4'hD, 8'h77, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      drive_cycle(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
      chk("conflict_cnt_flush", 32'(o_conflict_cnt), PERF ? 32'd6 : 32'd0);

      // Reset from RUN, then reset again at row 7 of the sweep: sweep restarts at row 0.
      idle_inputs();
      arst_n = 1'b0;
      #1;
      chk_reset_outputs("rst_run");
      arst_n = 1'b1;
      last_e = '0;
      sweep_rows(7, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 0);
      #1;
      arst_n = 1'b0;
      #1;
      chk_reset_outputs("rst_row7");
      arst_n = 1'b1;
      last_e = '0;
      sweep_rows(16, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 0);
      drive_cycle(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
